// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, head-flit field layout and NI state encodings.
package noc_pkg;

    localparam int FLIT_W    = 4;
    localparam int DEST_W    = 4;
    localparam int DST_X_LSB = 0;
    localparam int DST_X_W   = 2;
    localparam int DST_Y_LSB = 2;
    localparam int DST_Y_W   = 2;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HEAD,
        RX_BODY,
        RX_HOLD
    } rx_state_e;

endpackage

// File: rtl/noc_flit_deser.sv
// RX collector: captures a head flit plus PAYLOAD_FLITS body flits and holds the packet until the host takes it.
module noc_flit_deser #(
    parameter int FLIT_W        = noc_pkg::FLIT_W,
    parameter int PAYLOAD_FLITS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [FLIT_W-1:0]                 flit_in,
    input  logic                              flit_vld,
    input  logic                              host_rdy,
    output logic                              full,
    output logic                              pkt_vld,
    output logic [FLIT_W-1:0]                 pkt_dest,
    output logic [PAYLOAD_FLITS*FLIT_W-1:0]   pkt_payload,
    output logic                              err
);
    import noc_pkg::*;

    localparam int P  = PAYLOAD_FLITS * FLIT_W;
    localparam int CW = $clog2(PAYLOAD_FLITS + 1);

    rx_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FLIT_W-1:0]  dest_q, dest_d;
    logic [P-1:0]       payload_q, payload_d;
    logic               err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dest_d    = dest_q;
        payload_d = payload_q;
        err_d     = err_q;
        case (state_q)
            RX_HEAD: begin
                if (flit_vld) begin
                    dest_d  = flit_in;
                    cnt_d   = '0;
                    state_d = RX_BODY;
                end
            end
            RX_BODY: begin
                if (flit_vld) begin
                    for (int i = 0; i < PAYLOAD_FLITS; i++) begin
                        if (cnt_q == CW'(i)) payload_d[i*FLIT_W +: FLIT_W] = flit_in;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(PAYLOAD_FLITS - 1)) state_d = RX_HOLD;
                end
            end
            RX_HOLD: begin
                // Packet register is occupied: any arriving flit is lost.
                if (flit_vld) err_d = 1'b1;
                if (host_rdy) state_d = RX_HEAD;
            end
            default: state_d = RX_HEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RX_HEAD;
            cnt_q     <= '0;
            dest_q    <= '0;
            payload_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dest_q    <= dest_d;
            payload_q <= payload_d;
            err_q     <= err_d;
        end
    end

    assign full        = (state_q == RX_HOLD);
    assign pkt_vld     = (state_q == RX_HOLD);
    assign pkt_dest    = dest_q;
    assign pkt_payload = payload_q;
    assign err         = err_q;

endmodule

// File: rtl/local_port_ni.sv
// Router local-port network interface: serialises host packets into flits and reassembles received flits.
module local_port_ni #(
    parameter int FLIT_W        = noc_pkg::FLIT_W,
    parameter int PAYLOAD_FLITS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic [noc_pkg::DEST_W-1:0]        tx_dest,
    input  logic [PAYLOAD_FLITS*FLIT_W-1:0]   tx_payload,
    output logic [FLIT_W-1:0]                 local_in,
    output logic                              write_local,
    input  logic                              local_full,
    input  logic [FLIT_W-1:0]                 local_out,
    input  logic                              write_req_local,
    output logic                              ni_full,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [FLIT_W-1:0]                 rx_dest,
    output logic [PAYLOAD_FLITS*FLIT_W-1:0]   rx_payload,
    output logic                              rx_err
);
    import noc_pkg::*;

    localparam int P  = PAYLOAD_FLITS * FLIT_W;
    localparam int SW = P + FLIT_W;
    localparam int CW = $clog2(PAYLOAD_FLITS + 1);

    tx_state_e          tx_state_q, tx_state_d;
    logic [SW-1:0]      shift_q, shift_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [FLIT_W-1:0]  head;

    always_comb begin
        head = '0;
        head[DST_X_LSB +: DST_X_W] = tx_dest[DST_X_LSB +: DST_X_W];
        head[DST_Y_LSB +: DST_Y_W] = tx_dest[DST_Y_LSB +: DST_Y_W];
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        shift_d     = shift_q;
        tx_cnt_d    = tx_cnt_q;
        tx_ready    = 1'b0;
        write_local = 1'b0;
        local_in    = '0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    shift_d    = {tx_payload, head};
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                local_in = shift_q[FLIT_W-1:0];
                if (!local_full) begin
                    write_local = 1'b1;
                    shift_d     = shift_q >> FLIT_W;
                    if (tx_cnt_q == CW'(PAYLOAD_FLITS)) tx_state_d = TX_IDLE;
                    else                                tx_cnt_d   = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // The strobe is combinational, so suppress it in the reset cycle itself.
        if (reset) begin
            write_local = 1'b0;
            local_in    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            shift_q    <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            shift_q    <= shift_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    noc_flit_deser #(
        .FLIT_W        (FLIT_W),
        .PAYLOAD_FLITS (PAYLOAD_FLITS)
    ) u_deser (
        .clk         (clk),
        .reset       (reset),
        .flit_in     (local_out),
        .flit_vld    (write_req_local),
        .host_rdy    (rx_ready),
        .full        (ni_full),
        .pkt_vld     (rx_valid),
        .pkt_dest    (rx_dest),
        .pkt_payload (rx_payload),
        .err         (rx_err)
    );

endmodule

// File: tb/tb_local_port_ni.sv
// Directed bench for local_port_ni: per-cycle vector table plus back-to-back and reset sequences.
module tb_local_port_ni;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dest;
    logic [15:0] tx_payload;
    logic [3:0]  local_in;
    logic        write_local;
    logic        local_full;
    logic [3:0]  local_out;
    logic        write_req_local;
    logic        ni_full;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  rx_dest;
    logic [15:0] rx_payload;
    logic        rx_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    local_port_ni #(.FLIT_W(4), .PAYLOAD_FLITS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_dest         (tx_dest),
        .tx_payload      (tx_payload),
        .local_in        (local_in),
        .write_local     (write_local),
        .local_full      (local_full),
        .local_out       (local_out),
        .write_req_local (write_req_local),
        .ni_full         (ni_full),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rx_dest         (rx_dest),
        .rx_payload      (rx_payload),
        .rx_err          (rx_err)
    );

    typedef struct {
        logic        tv;
        logic [3:0]  dst;
        logic [15:0] pl;
        logic        lf;
        logic        wr;
        logic [3:0]  lo;
        logic        rr;
        logic        e_tr;
        logic        e_wl;
        logic [3:0]  e_li;
        logic        e_nf;
        logic        e_rv;
        logic [3:0]  e_rd;
        logic [15:0] e_rp;
        logic        e_er;
        logic        cd;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t mk(input logic tv, input logic [3:0] dst, input logic [15:0] pl,
                                input logic lf, input logic wr, input logic [3:0] lo, input logic rr,
                                input logic e_tr, input logic e_wl, input logic [3:0] e_li,
                                input logic e_nf, input logic e_rv, input logic [3:0] e_rd,
                                input logic [15:0] e_rp, input logic e_er, input logic cd);
        vec_t v;
        v.tv = tv; v.dst = dst; v.pl = pl; v.lf = lf; v.wr = wr; v.lo = lo; v.rr = rr;
        v.e_tr = e_tr; v.e_wl = e_wl; v.e_li = e_li; v.e_nf = e_nf; v.e_rv = e_rv;
        v.e_rd = e_rd; v.e_rp = e_rp; v.e_er = e_er; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        tx_valid = 0; tx_dest = 0; tx_payload = 0; local_full = 0;
        write_req_local = 0; local_out = 0; rx_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] got[8];
        int         n_got;
        bit         done;
        int         pat_wl[13];
        logic [3:0] pat_li[13];

        // TX single packet 6/BEEF, no stalls
        vecs[0]  = mk(1,4'h6,16'hBEEF,0,0,0,0, 1,0,4'h0, 0,0,4'h0,16'h0,0,1);
        vecs[1]  = mk(0,0,0,0,0,0,0,           0,1,4'h6, 0,0,4'h0,16'h0,0,1);
        vecs[2]  = mk(0,0,0,0,0,0,0,           0,1,4'hF, 0,0,4'h0,16'h0,0,1);
        vecs[3]  = mk(0,0,0,0,0,0,0,           0,1,4'hE, 0,0,4'h0,16'h0,0,1);
        vecs[4]  = mk(0,0,0,0,0,0,0,           0,1,4'hE, 0,0,4'h0,16'h0,0,1);
        vecs[5]  = mk(0,0,0,0,0,0,0,           0,1,4'hB, 0,0,4'h0,16'h0,0,1);
        vecs[6]  = mk(0,0,0,0,0,0,0,           1,0,4'h0, 0,0,4'h0,16'h0,0,1);
        // same packet, local_full for 3 cycles on the 2nd body flit
        vecs[7]  = mk(1,4'h6,16'hBEEF,0,0,0,0, 1,0,4'h0, 0,0,4'h0,16'h0,0,1);
        vecs[8]  = mk(0,0,0,0,0,0,0,           0,1,4'h6, 0,0,4'h0,16'h0,0,1);
        vecs[9]  = mk(0,0,0,0,0,0,0,           0,1,4'hF, 0,0,4'h0,16'h0,0,1);
        vecs[10] = mk(0,0,0,1,0,0,0,           0,0,4'hE, 0,0,4'h0,16'h0,0,1);
        vecs[11] = mk(0,0,0,1,0,0,0,           0,0,4'hE, 0,0,4'h0,16'h0,0,1);
        vecs[12] = mk(0,0,0,1,0,0,0,           0,0,4'hE, 0,0,4'h0,16'h0,0,1);
        vecs[13] = mk(0,0,0,0,0,0,0,           0,1,4'hE, 0,0,4'h0,16'h0,0,1);
        vecs[14] = mk(0,0,0,0,0,0,0,           0,1,4'hE, 0,0,4'h0,16'h0,0,1);
        vecs[15] = mk(0,0,0,0,0,0,0,           0,1,4'hB, 0,0,4'h0,16'h0,0,1);
        vecs[16] = mk(0,0,0,0,0,0,0,           1,0,4'h0, 0,0,4'h0,16'h0,0,1);
        // RX 9,1,2,3,4
        vecs[17] = mk(0,0,0,0,1,4'h9,0,        1,0,4'h0, 0,0,4'h0,16'h0,0,0);
        vecs[18] = mk(0,0,0,0,1,4'h1,0,        1,0,4'h0, 0,0,4'h0,16'h0,0,0);
        vecs[19] = mk(0,0,0,0,1,4'h2,0,        1,0,4'h0, 0,0,4'h0,16'h0,0,0);
        vecs[20] = mk(0,0,0,0,1,4'h3,0,        1,0,4'h0, 0,0,4'h0,16'h0,0,0);
        vecs[21] = mk(0,0,0,0,1,4'h4,0,        1,0,4'h0, 0,0,4'h0,16'h0,0,0);
        vecs[22] = mk(0,0,0,0,0,0,0,           1,0,4'h0, 1,1,4'h9,16'h4321,0,1);
        // overflow flit while holding, then host consumes
        vecs[23] = mk(0,0,0,0,1,4'h7,0,        1,0,4'h0, 1,1,4'h9,16'h4321,0,1);
        vecs[24] = mk(0,0,0,0,0,0,1,           1,0,4'h0, 1,1,4'h9,16'h4321,1,1);
        vecs[25] = mk(0,0,0,0,0,0,0,           1,0,4'h0, 0,0,4'h0,16'h0,1,0);
        // simultaneous TX 3/1234 and RX A,5,6,7,8; stray rx_ready while empty
        vecs[26] = mk(1,4'h3,16'h1234,0,1,4'hA,1, 1,0,4'h0, 0,0,4'h0,16'h0,1,0);
        vecs[27] = mk(0,0,0,0,1,4'h5,0,        0,1,4'h3, 0,0,4'h0,16'h0,1,0);
        vecs[28] = mk(0,0,0,0,1,4'h6,0,        0,1,4'h4, 0,0,4'h0,16'h0,1,0);
        vecs[29] = mk(0,0,0,0,1,4'h7,0,        0,1,4'h3, 0,0,4'h0,16'h0,1,0);
        vecs[30] = mk(0,0,0,0,1,4'h8,0,        0,1,4'h2, 0,0,4'h0,16'h0,1,0);
        vecs[31] = mk(0,0,0,0,0,0,0,           0,1,4'h1, 1,1,4'hA,16'h8765,1,1);
        vecs[32] = mk(0,0,0,0,0,0,1,           1,0,4'h0, 1,1,4'hA,16'h8765,1,1);
        vecs[33] = mk(0,0,0,0,0,0,0,           1,0,4'h0, 0,0,4'h0,16'h0,1,0);

        // reset state
        reset = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst tx_ready",    tx_ready, 1);
        chk("rst write_local", write_local, 0);
        chk("rst local_in",    local_in, 0);
        chk("rst ni_full",     ni_full, 0);
        chk("rst rx_valid",    rx_valid, 0);
        chk("rst rx_dest",     rx_dest, 0);
        chk("rst rx_payload",  rx_payload, 0);
        chk("rst rx_err",      rx_err, 0);
        reset = 0;

        for (int i = 0; i < 34; i++) begin
            tx_valid = vecs[i].tv; tx_dest = vecs[i].dst; tx_payload = vecs[i].pl;
            local_full = vecs[i].lf; write_req_local = vecs[i].wr; local_out = vecs[i].lo;
            rx_ready = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("v%0d tx_ready", i),    tx_ready,    vecs[i].e_tr);
            chk($sformatf("v%0d write_local", i), write_local, vecs[i].e_wl);
            chk($sformatf("v%0d local_in", i),    local_in,    vecs[i].e_li);
            chk($sformatf("v%0d ni_full", i),     ni_full,     vecs[i].e_nf);
            chk($sformatf("v%0d rx_valid", i),    rx_valid,    vecs[i].e_rv);
            chk($sformatf("v%0d rx_err", i),      rx_err,      vecs[i].e_er);
            if (vecs[i].cd) begin
                chk($sformatf("v%0d rx_dest", i),    rx_dest,    vecs[i].e_rd);
                chk($sformatf("v%0d rx_payload", i), rx_payload, vecs[i].e_rp);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // back-to-back TX with tx_valid held until the 2nd packet is accepted
        pat_wl = '{0,1,1,1,1,1,0,1,1,1,1,1,0};
        pat_li = '{4'h0,4'h1,4'h5,4'h5,4'h5,4'h5,4'h0,4'h1,4'h5,4'h5,4'h5,4'h5,4'h0};
        tx_valid = 1; tx_dest = 4'h1; tx_payload = 16'h5555;
        for (int c = 0; c < 13; c++) begin
            if (c == 7) tx_valid = 0;
            @(negedge clk);
            chk($sformatf("b2b c%0d write_local", c), write_local, pat_wl[c]);
            chk($sformatf("b2b c%0d tx_ready", c),    tx_ready,    !pat_wl[c]);
            chk($sformatf("b2b c%0d local_in", c),    local_in,    pat_li[c]);
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // reset mid TX and mid RX
        tx_valid = 1; tx_dest = 4'h6; tx_payload = 16'hBEEF;
        write_req_local = 1; local_out = 4'h9;
        @(posedge clk); #1;
        tx_valid = 0; local_out = 4'h1;
        @(negedge clk);
        chk("mid flit0", local_in, 4'h6);
        @(posedge clk); #1;
        local_out = 4'h2;
        @(negedge clk);
        chk("mid flit1", local_in, 4'hF);
        chk("mid strobe", write_local, 1);
        @(posedge clk); #1;
        reset = 1; write_req_local = 0;
        @(negedge clk);
        chk("rstcyc write_local", write_local, 0);
        @(posedge clk); #1;
        reset = 0;
        tx_valid = 1; tx_dest = 4'hC; tx_payload = 16'hA5C3;
        @(negedge clk);
        chk("post tx_ready",    tx_ready, 1);
        chk("post write_local", write_local, 0);
        chk("post rx_valid",    rx_valid, 0);
        chk("post ni_full",     ni_full, 0);
        chk("post rx_err",      rx_err, 0);

        // loop the TX flits straight back into RX
        n_got = 0;
        done  = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            tx_valid = 0;
            @(negedge clk);
            if (rx_valid) done = 1;
            else begin
                write_req_local = write_local;
                local_out       = local_in;
                if (write_local && n_got < 8) begin
                    got[n_got] = local_in;
                    n_got++;
                end
            end
        end
        chk("loop done",  done, 1);
        chk("loop flits", n_got, 5);
        chk("loop f0", got[0], 4'hC);
        chk("loop f1", got[1], 4'h3);
        chk("loop f2", got[2], 4'hC);
        chk("loop f3", got[3], 4'h5);
        chk("loop f4", got[4], 4'hA);
        chk("loop rx_dest",    rx_dest, 4'hC);
        chk("loop rx_payload", rx_payload, 16'hA5C3);
        chk("loop ni_full",    ni_full, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
